// File: rtl/inst_fetch_pkg.sv
// Shared widths, constants and types for the instruction fetch unit.
// The fetch queue stores whole {pc, inst} pairs as one entry.
package inst_fetch_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;

   localparam logic [INST_W-1:0]      ZERO_WORD        = 32'h0000_0000;
   localparam logic                   CHIP_ENABLE      = 1'b1;
   localparam logic                   CHIP_DISABLE     = 1'b0;
   localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [INST_ADDR_W-1:0] pc;
      logic [INST_W-1:0]      inst;
   } fetch_entry_t;

   // Clears the byte-offset bits so every fetch address is word aligned.
   function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, inst} entries between the ROM and ID.
// clear wins over push/pop; an empty queue presents an all-zero head.
module fetch_queue
   import inst_fetch_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          clear_i,
   input  fetch_entry_t  data_i,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o,
   output fetch_entry_t  head_o
);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push_s;
   logic          do_pop_s;

   // Status flags, head view and qualified push/pop.
   always_comb begin
      full_o    = (count_q == CW'(DEPTH));
      empty_o   = (count_q == {CW{1'b0}});
      count_o   = count_q;
      do_pop_s  = pop_i && !empty_o;
      do_push_s = push_i && (!full_o || do_pop_s);
      if (empty_o) begin
         head_o = '{pc: ZERO_WORD, inst: ZERO_WORD};
      end else begin
         head_o = mem_q[rd_ptr_q];
      end
   end

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '{pc: ZERO_WORD, inst: ZERO_WORD};
         end
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives the ROM request and feeds a small
// {pc, inst} queue toward ID, with backpressure, branch and flush redirect.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int                     QDEPTH   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   rom_ce_o,
   output logic [INST_ADDR_W-1:0] rom_addr_o,
   input  logic [INST_W-1:0]      rom_inst_i,
   output logic                   id_valid_o,
   output logic [INST_ADDR_W-1:0] id_pc_o,
   output logic [INST_W-1:0]      id_inst_o,
   input  logic                   id_ready_i,
   input  logic                   branch_flag_i,
   input  logic [INST_ADDR_W-1:0] branch_target_i,
   input  logic                   flush_i,
   input  logic [INST_ADDR_W-1:0] new_pc_i
);

   localparam int CW = $clog2(QDEPTH) + 1;

   fetch_state_e           state_q, state_d;
   logic [INST_ADDR_W-1:0] pc_q, pc_d;
   logic                   redirect_s;
   logic                   pop_s;
   logic                   space_s;
   logic                   push_s;
   logic                   q_full_s;
   logic                   q_empty_s;
   logic [CW-1:0]          q_count_s;
   fetch_entry_t           head_s;
   fetch_entry_t           push_entry_s;

   // ROM is enabled only when the returned word is guaranteed a queue slot.
   always_comb begin
      redirect_s   = flush_i || branch_flag_i;
      pop_s        = id_ready_i && !q_empty_s;
      space_s      = !q_full_s || pop_s;
      push_s       = (state_q == FETCH) && space_s && !redirect_s;
      rom_addr_o   = pc_q;
      push_entry_s = '{pc: pc_q, inst: rom_inst_i};
      id_valid_o   = (q_count_s != {CW{1'b0}});
      id_pc_o      = head_s.pc;
      id_inst_o    = head_s.inst;
      if (push_s) begin
         rom_ce_o = CHIP_ENABLE;
      end else begin
         rom_ce_o = CHIP_DISABLE;
      end
   end

   // Next state and PC; flush outranks branch, targets forced word aligned.
   always_comb begin
      case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   state_d = FETCH;
         default: state_d = IDLE;
      endcase
      if (flush_i) begin
         pc_d = word_align(new_pc_i);
      end else if (branch_flag_i) begin
         pc_d = word_align(branch_target_i);
      end else if (push_s) begin
         pc_d = pc_q + 32'd4;
      end else begin
         pc_d = pc_q;
      end
   end

   // FSM and PC registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_queue #(
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .clear_i (redirect_s),
      .data_i  (push_entry_s),
      .full_o  (q_full_s),
      .empty_o (q_empty_s),
      .count_o (q_count_s),
      .head_o  (head_s)
   );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table, hand sequences
// for async reset and PC wrap, and random traffic against a queue model.
module tb_inst_fetch;

   localparam int QD = 2;

   logic        clk;
   logic        rst;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_ready;
   logic        br_flag;
   logic [31:0] br_tgt;
   logic        flush;
   logic [31:0] new_pc;

   logic        w_rst;
   logic        w_ce;
   logic [31:0] w_addr;
   logic [31:0] w_rom;
   logic        w_valid;
   logic [31:0] w_pc;
   logic [31:0] w_inst;
   logic        w_ready;
   logic        w_br;
   logic [31:0] w_tgt;
   logic        w_fl;
   logic [31:0] w_npc;

   int n_checks;
   int n_fail;

   // Behavioural model state: expected queue contents, PC, started flag.
   logic [63:0] mq[$];
   logic [31:0] m_pc;
   bit          m_run;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   assign rom_inst = rom_word(rom_addr);
   assign w_rom    = rom_word(w_addr);

   inst_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(QD)) dut (
      .clk(clk), .rst(rst), .rom_ce_o(rom_ce), .rom_addr_o(rom_addr),
      .rom_inst_i(rom_inst), .id_valid_o(id_valid), .id_pc_o(id_pc),
      .id_inst_o(id_inst), .id_ready_i(id_ready), .branch_flag_i(br_flag),
      .branch_target_i(br_tgt), .flush_i(flush), .new_pc_i(new_pc)
   );

   inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(QD)) dut_wrap (
      .clk(clk), .rst(w_rst), .rom_ce_o(w_ce), .rom_addr_o(w_addr),
      .rom_inst_i(w_rom), .id_valid_o(w_valid), .id_pc_o(w_pc),
      .id_inst_o(w_inst), .id_ready_i(w_ready), .branch_flag_i(w_br),
      .branch_target_i(w_tgt), .flush_i(w_fl), .new_pc_i(w_npc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   typedef struct {
      logic        ready;
      logic        br;
      logic [31:0] tgt;
      logic        fl;
      logic [31:0] npc;
      logic        ce;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   function automatic vec_t mk(input logic rdy, input logic b, input logic [31:0] t,
                               input logic f, input logic [31:0] n, input logic c,
                               input logic [31:0] a, input logic v, input logic [31:0] p);
      vec_t r;
      r.ready = rdy; r.br = b; r.tgt = t; r.fl = f; r.npc = n;
      r.ce = c; r.addr = a; r.valid = v; r.pc = p;
      return r;
   endfunction

   // One model-checked cycle: drive at negedge, compare, then advance the model.
   task automatic mstep(input logic rdy, input logic b, input logic [31:0] t,
                        input logic f, input logic [31:0] n);
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_pop;
      logic        e_redir;
      logic        e_ce;
      logic [63:0] tmp;
      @(negedge clk);
      id_ready = rdy; br_flag = b; br_tgt = t; flush = f; new_pc = n;
      #1;
      e_valid = (mq.size() > 0);
      e_pc    = e_valid ? mq[0][63:32] : 32'h0;
      e_inst  = e_valid ? mq[0][31:0]  : 32'h0;
      e_pop   = e_valid && rdy;
      e_redir = b || f;
      e_ce    = m_run && ((mq.size() < QD) || e_pop) && !e_redir;
      chk("rnd_ce",    {31'h0, rom_ce},   {31'h0, e_ce});
      chk("rnd_addr",  rom_addr,          m_pc);
      chk("rnd_valid", {31'h0, id_valid}, {31'h0, e_valid});
      chk("rnd_pc",    id_pc,             e_pc);
      chk("rnd_inst",  id_inst,           e_inst);
      @(posedge clk);
      if (e_redir) begin
         mq.delete();
         m_pc = (f ? n : t) & 32'hFFFF_FFFC;
      end else begin
         if (e_pop) tmp = mq.pop_front();
         if (e_ce) begin
            mq.push_back({m_pc, rom_word(m_pc)});
            m_pc = m_pc + 32'd4;
         end
      end
      m_run = 1'b1;
   endtask

   vec_t tbl[17];
   logic [31:0] wexp_addr  [5] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
   logic [31:0] wexp_pc    [5] = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
   logic        wexp_ce    [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic        wexp_valid [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   initial begin
      n_checks = 0; n_fail = 0;
      rst = 1'b0; id_ready = 1'b0; br_flag = 1'b0; br_tgt = 32'h0; flush = 1'b0; new_pc = 32'h0;
      w_rst = 1'b0; w_ready = 1'b1; w_br = 1'b0; w_tgt = 32'h0; w_fl = 1'b0; w_npc = 32'h0;

      //             rdy br tgt           fl npc           ce addr          v  pc
      tbl[0]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h000, 1'b0, 32'h000);
      tbl[1]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 32'h000, 1'b0, 32'h000);
      tbl[2]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 32'h004, 1'b1, 32'h000);
      tbl[3]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 32'h008, 1'b1, 32'h004);
      tbl[4]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 32'h00C, 1'b1, 32'h008);
      tbl[5]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h010, 1'b1, 32'h008);
      tbl[6]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h010, 1'b1, 32'h008);
      tbl[7]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 32'h010, 1'b1, 32'h008);
      tbl[8]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h014, 1'b1, 32'h00C);
      tbl[9]  = mk(1'b0, 1'b1, 32'h100, 1'b0, 32'h0,  1'b0, 32'h014, 1'b1, 32'h00C);
      tbl[10] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 32'h100, 1'b0, 32'h000);
      tbl[11] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 32'h104, 1'b1, 32'h100);
      tbl[12] = mk(1'b1, 1'b1, 32'h100, 1'b1, 32'h20, 1'b0, 32'h108, 1'b1, 32'h104);
      tbl[13] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 32'h020, 1'b0, 32'h000);
      tbl[14] = mk(1'b1, 1'b1, 32'h103, 1'b0, 32'h0,  1'b0, 32'h024, 1'b1, 32'h020);
      tbl[15] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 32'h100, 1'b0, 32'h000);
      tbl[16] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 32'h104, 1'b1, 32'h100);

      // Reset state while rst is held low.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ce",    {31'h0, rom_ce},   32'h0);
      chk("rst_addr",  rom_addr,          32'h0);
      chk("rst_valid", {31'h0, id_valid}, 32'h0);
      chk("rst_pc",    id_pc,             32'h0);
      chk("rst_inst",  id_inst,           32'h0);

      @(posedge clk); #1 rst = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         id_ready = tbl[i].ready; br_flag = tbl[i].br; br_tgt = tbl[i].tgt;
         flush = tbl[i].fl; new_pc = tbl[i].npc;
         #1;
         chk($sformatf("v%0d_ce", i),    {31'h0, rom_ce},   {31'h0, tbl[i].ce});
         chk($sformatf("v%0d_addr", i),  rom_addr,          tbl[i].addr);
         chk($sformatf("v%0d_valid", i), {31'h0, id_valid}, {31'h0, tbl[i].valid});
         chk($sformatf("v%0d_pc", i),    id_pc,             tbl[i].pc);
         chk($sformatf("v%0d_inst", i),  id_inst,           tbl[i].valid ? rom_word(tbl[i].pc) : 32'h0);
      end

      // Fill the queue to two entries, then drop reset between edges.
      @(negedge clk);
      id_ready = 1'b0;
      #1;
      chk("pre_rst_ce",    {31'h0, rom_ce},   32'h1);
      chk("pre_rst_valid", {31'h0, id_valid}, 32'h1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_ce",    {31'h0, rom_ce},   32'h0);
      chk("mid_rst_valid", {31'h0, id_valid}, 32'h0);
      chk("mid_rst_addr",  rom_addr,          32'h0);
      chk("mid_rst_pc",    id_pc,             32'h0);
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b1;
      mq.delete(); m_pc = 32'h0; m_run = 1'b0;
      mstep(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      mstep(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      mstep(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         mstep(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), $urandom,
               ($urandom_range(0, 15) == 0), $urandom);
      end
      for (int k = 0; k < 6; k++) begin
         mstep(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      end

      // PC wrap from RESET_PC = FFFF_FFF8.
      @(posedge clk); #1 w_rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("wrap%0d_ce", k),    {31'h0, w_ce},    {31'h0, wexp_ce[k]});
         chk($sformatf("wrap%0d_addr", k),  w_addr,           wexp_addr[k]);
         chk($sformatf("wrap%0d_valid", k), {31'h0, w_valid}, {31'h0, wexp_valid[k]});
         chk($sformatf("wrap%0d_pc", k),    w_pc,             wexp_pc[k]);
         chk($sformatf("wrap%0d_inst", k),  w_inst,           wexp_valid[k] ? rom_word(wexp_pc[k]) : 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Requester side of the instruction ROM interface.
- Holds the PC and drives the ROM's chip-enable and byte address.
- Captures each returned instruction together with its PC into a small queue toward ID, using a valid/ready handshake.
- Handles pipeline backpressure, branch redirect and flush-to-vector, so the ROM is only enabled when the result can be stored.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 00.
- QDEPTH, 2, fetch queue depth in entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rom_ce_o  out  1  ROM chip enable; 1 = ChipEnable.
- rom_addr_o  out  32  ROM byte address; word-aligned.
- rom_inst_i  in  32  ROM data; combinational, valid in the same cycle as ce/addr.
- id_valid_o  out  1  queue head holds an instruction.
- id_pc_o  out  32  PC of head entry.
- id_inst_o  out  32  instruction of head entry.
- id_ready_i  in  1  ID accepts head this cycle; pop = id_valid_o && id_ready_i.
- branch_flag_i  in  1  redirect request, single-cycle pulse.
- branch_target_i  in  32  redirect address.
- flush_i  in  1  exception/flush request.
- new_pc_i  in  32  flush vector.

Behaviour:
Reset (rst=0, asynchronous):
- pc=RESET_PC, state=IDLE, queue empty.
- Outputs: rom_ce_o=0, rom_addr_o=RESET_PC, id_valid_o=0, id_pc_o=0, id_inst_o=0.

States:
- IDLE: rom_ce_o=0. Goes to FETCH on the first rising edge with rst=1.
- FETCH:
  - rom_ce_o = space && !redirect, where space = (count<QDEPTH) || pop and redirect = flush_i || branch_flag_i.
  - rom_addr_o = pc.
- No other states. A full queue is the condition "space=0" within FETCH, not a separate state.

Fetch push (edge with rom_ce_o=1):
- Push {pc, rom_inst_i}; pc <= pc+4.
- PC arithmetic is 32-bit with wrap: 32'hFFFF_FFFC + 4 = 0.

Full queue:
- When space=0, rom_ce_o=0 and pc holds.
- No instruction is read unless it is stored.

Simultaneous push and pop:
- Both happen in the same edge; count is unchanged.

Output latency and ordering:
- An instruction fetched in cycle N is visible on id_* in cycle N+1 when the queue was empty.
- Order is strictly FIFO.

Output stability:
- While id_valid_o=1 and id_ready_i=0, id_pc_o and id_inst_o are held constant, unless a redirect occurs.

Redirect, on the edge where it is sampled:
- Queue is cleared, including the head even if popped that cycle. A pop in the same cycle still counts as consumed by ID.
- No push occurs in that cycle.
- Target selection: pc <= new_pc_i if flush_i, else branch_target_i. flush_i has priority.
- Target bits [1:0] are forced to 00. No alignment fault is raised.
- Redirect penalty: target instruction is on id_* two cycles after the redirect edge.
- A redirect while in IDLE loads pc and still moves to FETCH.

Delay slots:
- No delay-slot preservation in this block. A delay-slot instruction already delivered to ID is ID's responsibility.

Empty queue outputs:
- id_pc_o and id_inst_o = 0 (ZeroWord).

Mid-operation reset:
- Asserting rst at any point immediately forces rom_ce_o=0 and id_valid_o=0.
- Queued instructions are discarded.

Decomposition:
- Shared defines/package:
  - ZeroWord, ChipEnable, ChipDisable, InstAddrBus, InstBus widths.
  - RESET_PC default.
  - IDLE/FETCH state encodings.
- Sub-module fetch_queue:
  - Synchronous FIFO, width 64 ({pc, inst}), depth QDEPTH.
  - Ports: push, pop, clear, full, empty, count, head data.
  - Async active-low reset.
  - clear has priority over push.

Test Plan:
1. Reset/startup:
   - Hold rst=0: rom_ce_o=0, rom_addr_o=0, id_valid_o=0.
   - Release with id_ready_i=1: cycle 1 ce=1, addr=0x0; then addr 0x4, 0x8.
   - id_pc_o follows one cycle behind.
2. Backpressure:
   - id_ready_i=0 from start: entries 0x0 and 0x4 queue, then ce=0 with addr held at 0x8.
   - Raise id_ready_i: pops in order 0x0, 0x4, 0x8; ce is 1 in the same cycle as the first pop.
3. Branch with full queue:
   - branch_flag_i=1, target 0x100: next cycle id_valid_o=0, addr=0x100.
   - Following cycle id_pc_o=0x100 with the ROM word at 0x100.
4. Priority:
   - flush_i=1 with new_pc_i=0x20, and branch_flag_i=1 with target 0x100, in the same cycle: fetch resumes at 0x20.
   - Misaligned target 0x103 fetches 0x100.
5. Wrap:
   - RESET_PC=32'hFFFF_FFF8: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
   - PCs delivered to ID in that order.
6. Async reset mid-stream:
   - Drop rst between edges with 2 entries queued: ce=0 and id_valid_o=0 before the next edge.
   - After release, fetch restarts at RESET_PC.
